// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light slice: lamp codes, FSM state codes
// and the elaboration-time parameter sanity check.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    typedef enum logic [2:0] {
        HG    = 3'd0,
        HY    = 3'd1,
        AR1   = 3'd2,
        FG    = 3'd3,
        FY    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam int MIN_DURATION = 1;
    localparam int MAX_TW       = 30;

    function automatic bit params_ok(input int long_t, input int short_t,
                                     input int allred_t, input int min_fg,
                                     input int tw);
        longint unsigned limit;
        if (tw < 1 || tw > MAX_TW) return 1'b0;
        limit = longint'(1) << tw;
        return (long_t   >= MIN_DURATION) && (longint'(long_t)   < limit) &&
               (short_t  >= MIN_DURATION) && (longint'(short_t)  < limit) &&
               (allred_t >= MIN_DURATION) && (longint'(allred_t) < limit) &&
               (min_fg   >= MIN_DURATION) && (min_fg <= long_t);
    endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Sensor/strobe inputs and lamp/status outputs of the traffic-light controller.
interface traffic_light_fsm_if #(
    parameter int TW = 8
);
    logic          sec_en;
    logic          car;
    logic          flash;
    logic [1:0]    hwy_light;
    logic [1:0]    farm_light;
    logic [2:0]    state_o;
    logic [TW-1:0] timer_o;

    modport master (
        output sec_en, car, flash,
        input  hwy_light, farm_light, state_o, timer_o
    );

    modport slave (
        input  sec_en, car, flash,
        output hwy_light, farm_light, state_o, timer_o
    );
endinterface

// File: rtl/tl_sec_timer.sv
// Saturating seconds counter; 'reached' is high when the second being
// counted now (count+1) has reached the supplied limit.
module tl_sec_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    input  logic [TW-1:0] limit,
    output logic [TW-1:0] count,
    output logic          reached
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {TW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    // One extra bit so a saturated count still compares correctly.
    assign reached = ({1'b0, count} + (TW+1)'(1)) >= {1'b0, limit};

endmodule

// File: rtl/traffic_light_fsm.sv
// Highway/farm-road light sequencer with highway priority, bounded farm green
// and a maintenance flashing-yellow override.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int LONG_T   = 5,
    parameter int SHORT_T  = 2,
    parameter int ALLRED_T = 1,
    parameter int MIN_FG   = 2,
    parameter int TW       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    traffic_light_fsm_if.slave  bus
);

    if (!params_ok(LONG_T, SHORT_T, ALLRED_T, MIN_FG, TW)) begin : g_bad_params
        $error("traffic_light_fsm: illegal timing parameters");
    end

    state_t        state;
    state_t        state_next;
    logic          phase;
    logic          phase_next;
    logic [TW-1:0] limit;
    logic [TW-1:0] count;
    logic          reached;
    logic          timer_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HG;
            phase <= 1'b0;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    // In FG, with MIN_FG <= LONG_T, the exit rule reduces to choosing the limit by car.
    always_comb begin
        limit = TW'(ALLRED_T);
        case (state)
            HG:      limit = TW'(LONG_T);
            HY, FY:  limit = TW'(SHORT_T);
            FG:      limit = bus.car ? TW'(LONG_T) : TW'(MIN_FG);
            default: limit = TW'(ALLRED_T);
        endcase
    end

    always_comb begin
        state_next = state;
        if (bus.flash) begin
            state_next = FLASH;
        end else begin
            case (state)
                HG:      if (bus.sec_en && bus.car && reached) state_next = HY;
                HY:      if (bus.sec_en && reached)            state_next = AR1;
                AR1:     if (bus.sec_en && reached)            state_next = FG;
                FG:      if (bus.sec_en && reached)            state_next = FY;
                FY:      if (bus.sec_en && reached)            state_next = AR2;
                AR2:     if (bus.sec_en && reached)            state_next = HG;
                FLASH:   state_next = AR2;
                default: state_next = AR2;
            endcase
        end
    end

    assign timer_clear = (state_next != state);
    assign phase_next  = (state == FLASH && state_next == FLASH) ? (phase ^ bus.sec_en) : 1'b0;

    tl_sec_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .inc     (bus.sec_en),
        .limit   (limit),
        .count   (count),
        .reached (reached)
    );

    // Lamps come from registered state only; unknown codes show all-red.
    always_comb begin
        bus.hwy_light  = RED;
        bus.farm_light = RED;
        case (state)
            HG: bus.hwy_light  = GREEN;
            HY: bus.hwy_light  = YELLOW;
            FG: bus.farm_light = GREEN;
            FY: bus.farm_light = YELLOW;
            FLASH: begin
                bus.hwy_light  = phase ? OFF : YELLOW;
                bus.farm_light = phase ? OFF : YELLOW;
            end
            default: begin
                bus.hwy_light  = RED;
                bus.farm_light = RED;
            end
        endcase
    end

    assign bus.state_o = state;
    assign bus.timer_o = count;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a seconds-level behavioural model of the light rules.
module tb_traffic_light_fsm;

    localparam int LONG_T   = 5;
    localparam int SHORT_T  = 2;
    localparam int ALLRED_T = 1;
    localparam int MIN_FG   = 2;
    localparam int TW       = 8;
    localparam int TMAX     = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int m_state = 0;
    int m_timer = 0;
    int m_phase = 0;
    int prev_obs;

    traffic_light_fsm_if #(.TW(TW)) bus ();

    traffic_light_fsm #(
        .LONG_T(LONG_T), .SHORT_T(SHORT_T), .ALLRED_T(ALLRED_T),
        .MIN_FG(MIN_FG), .TW(TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Road lamps by phase: 0 HG,1 HY,2 AR1,3 FG,4 FY,5 AR2 (2=green,1=yellow,0=red).
    function automatic int hwyLamp(input int s, input int ph);
        int tbl[6] = '{2, 1, 0, 0, 0, 0};
        if (s == 6) return ph ? 3 : 1;
        return tbl[s];
    endfunction

    function automatic int farmLamp(input int s, input int ph);
        int tbl[6] = '{0, 0, 0, 2, 1, 0};
        if (s == 6) return ph ? 3 : 1;
        return tbl[s];
    endfunction

    function automatic int modelNext(input int s, input int t, input bit sec, input bit c, input bit f);
        int n = t + 1;
        if (f)       return 6;
        if (s == 6)  return 5;
        if (!sec)    return s;
        case (s)
            0: return (c && n >= LONG_T) ? 1 : 0;
            1: return (n >= SHORT_T) ? 2 : 1;
            2: return (n >= ALLRED_T) ? 3 : 2;
            3: return ((n >= MIN_FG && !c) || n >= LONG_T) ? 4 : 3;
            4: return (n >= SHORT_T) ? 5 : 4;
            default: return (n >= ALLRED_T) ? 0 : 5;
        endcase
    endfunction

    task automatic checkAll(input bit sec);
        int h = int'(bus.hwy_light);
        int fl = int'(bus.farm_light);
        int s = int'(bus.state_o);
        checkOutput("state", s, m_state);
        checkOutput("timer", int'(bus.timer_o), m_timer);
        checkOutput("hwy", h, hwyLamp(m_state, m_phase));
        checkOutput("farm", fl, farmLamp(m_state, m_phase));
        checkOutput("dual_green", int'(h == 2 && fl == 2), 0);
        if (s != 6) checkOutput("safety", int'(h != 0 && fl != 0), 0);
        if (s != prev_obs && s != 6 && prev_obs != 6) checkOutput("sec_align", int'(sec), 1);
        prev_obs = s;
    endtask

    task automatic applyStimulus(input bit sec, input bit c, input bit f);
        int nxt;
        @(negedge clk);
        bus.sec_en = sec;
        bus.car    = c;
        bus.flash  = f;
        @(posedge clk);
        nxt = modelNext(m_state, m_timer, sec, c, f);
        if (nxt != m_state)      m_timer = 0;
        else if (sec)            m_timer = (m_timer < TMAX) ? m_timer + 1 : TMAX;
        m_phase  = (nxt == 6 && m_state == 6) ? (m_phase ^ int'(sec)) : 0;
        m_state  = nxt;
        #1;
        checkAll(sec);
    endtask

    task automatic pulse(input bit c, input bit f);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, c, f);
        applyStimulus(1'b1, c, f);
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.sec_en = 1'b0;
        bus.car    = 1'b0;
        bus.flash  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_state = 0;
        m_timer = 0;
        m_phase = 0;
        checkOutput("rst_state", int'(bus.state_o), 0);
        checkOutput("rst_timer", int'(bus.timer_o), 0);
        checkOutput("rst_hwy", int'(bus.hwy_light), 2);
        checkOutput("rst_farm", int'(bus.farm_light), 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_obs = 0;
    endtask

    initial begin
        int exp_after[16] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 0};
        bit c, f;
        bus.sec_en = 1'b0;
        bus.car    = 1'b0;
        bus.flash  = 1'b0;
        prev_obs   = 0;
        repeat (3) @(posedge clk);
        doReset();

        // Idle highway: timer saturates, lamps never move.
        for (int p = 0; p < 300; p++) pulse(1'b0, 1'b0);
        checkOutput("idle_sat_timer", int'(bus.timer_o), 255);
        checkOutput("idle_state", int'(bus.state_o), 0);

        // Full cycle with a car waiting the whole time.
        doReset();
        for (int p = 0; p < 16; p++) begin
            pulse(1'b1, 1'b0);
            checkOutput($sformatf("cycle_p%0d", p + 1), int'(bus.state_o), exp_after[p]);
        end

        // Async reset while in HY.
        doReset();
        for (int p = 0; p < 6; p++) pulse(1'b1, 1'b0);
        checkOutput("pre_rst_hy", int'(bus.state_o), 1);
        doReset();

        // Car leaves after the first farm-green second: minimum green applies.
        for (int p = 0; p < 8; p++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        checkOutput("min_fg_hold", int'(bus.state_o), 3);
        pulse(1'b0, 1'b0);
        checkOutput("min_fg_exit", int'(bus.state_o), 4);
        checkOutput("min_fg_timer0", int'(bus.timer_o), 0);

        // Flash requested mid-FG together with a second strobe.
        doReset();
        for (int p = 0; p < 9; p++) pulse(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("flash_enter", int'(bus.state_o), 6);
        checkOutput("flash_lamp0", int'(bus.hwy_light), 1);
        pulse(1'b1, 1'b1);
        checkOutput("flash_lamp1", int'(bus.farm_light), 3);
        pulse(1'b1, 1'b1);
        checkOutput("flash_lamp2", int'(bus.hwy_light), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("flash_exit", int'(bus.state_o), 5);
        pulse(1'b1, 1'b0);
        checkOutput("flash_to_hg", int'(bus.state_o), 0);

        // Random traffic, flash requests and strobes.
        c = 1'b0;
        f = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) c = ~c;
            if (f) f = ($urandom_range(0, 19) != 0);
            else   f = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 3) == 0, c, f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
